mu0_control: RTL and testbench
==============================

// Module: mu0_control
// PURPOSE
//  Control FSM for the MU0 16-bit processor. Sequences fetch/execute and
//  drives the selects of the datapath's 2:1 16-bit muxes (X, Y, address),
//  the register enables, ALU function and memory strobes.
//  Sits directly upstream of the mux stage and the PC/IR/ACC registers.
// PARAMETERS
//  WAIT_EN  1  1: honour mem_ready handshake; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk       in   1  system clock, rising edge
//  reset     in   1  asynchronous, active-high reset
//  F         in   4  opcode, IR[15:12]
//  N         in   1  ACC negative flag (ACC[15])
//  Z         in   1  ACC zero flag
//  mem_ready in   1  memory completes current Rd/Wr this cycle
//  X_sel     out  1  X mux: 0=ACC, 1=PC
//  Y_sel     out  1  Y mux: 0=memory data, 1=IR[11:0] zero-extended
//  Addr_sel  out  1  address mux: 0=PC, 1=IR[11:0]
//  PC_En     out  1  PC load enable
//  IR_En     out  1  IR load enable
//  Acc_En    out  1  ACC load enable
//  ALU_fs    out  2  00=Y, 01=X+Y, 10=X+1, 11=X-Y
//  Rd        out  1  memory read strobe
//  Wr        out  1  memory write strobe
//  Halted    out  1  high in HALT state
// BEHAVIOUR
//  - States: FETCH, EXECUTE, HALT (2-bit state register, clocked on clk).
//  - reset high: state->FETCH immediately; while reset high ALL outputs 0.
//  - Outputs are combinational decode of state, F, N, Z, mem_ready.
//    Unlisted outputs are 0 in every state; selects default 0.
//  - FETCH: Addr_sel=0, Rd=1, X_sel=1, ALU_fs=10; IR_En=PC_En=mem_ready.
//    mem_ready=1 -> EXECUTE; else stay FETCH, Rd held high.
//  - EXECUTE by F:
//    0 LDA: Addr_sel=1, Rd=1, Y_sel=0, ALU_fs=00, Acc_En=mem_ready
//    1 STA: Addr_sel=1, Wr=1, X_sel=0 (ACC drives write data)
//    2 ADD: Addr_sel=1, Rd=1, X_sel=0, Y_sel=0, ALU_fs=01, Acc_En=mem_ready
//    3 SUB: as ADD, ALU_fs=11
//    4 JMP: Y_sel=1, ALU_fs=00, PC_En=1 (no memory access)
//    5 JGE: as JMP but PC_En=~N
//    6 JNE: as JMP but PC_En=~Z
//    7 STP and 8-F: no enables, no strobes; next state HALT
//  - Memory ops (LDA/STA/ADD/SUB) leave EXECUTE for FETCH only when
//    mem_ready=1; otherwise hold EXECUTE with Addr_sel/Rd/Wr stable and
//    enables 0. Jumps/untaken jumps return to FETCH after 1 cycle.
//  - Untaken JGE/JNE: all enables 0, 1 cycle, -> FETCH.
//  - HALT: Halted=1, all else 0; exited only by reset.
//  - Latency, zero-wait memory: 2 cycles per instruction.
//  - Rd and Wr never both 1; at most one of IR_En/Acc_En per cycle.
//  - Reset mid-wait: strobes drop the same cycle; resume in FETCH.
// TESTING
//  1 reset then release, mem_ready=1: cycle0 FETCH Rd=1 IR_En=PC_En=1
//    ALU_fs=10; cycle1 EXECUTE per F.
//  2 F=2 ADD, mem_ready low 3 cycles in EXECUTE: Rd=1 Addr_sel=1 held,
//    Acc_En=0 for 3 cycles, Acc_En=1 on 4th, then FETCH.
//  3 F=5 JGE with N=1 -> PC_En=0; N=0 -> PC_En=1, Y_sel=1, ALU_fs=00.
//    F=6 JNE with Z=1 -> PC_En=0; Z=0 -> PC_En=1.
//  4 F=1 STA: Wr=1, Rd=0, X_sel=0, Addr_sel=1, no enables.
//  5 F=7 and F=4'hC: one EXECUTE cycle, then Halted=1 stable 10 cycles
//    regardless of mem_ready; assert reset -> Halted=0, FETCH.
//  6 assert reset mid-FETCH wait with Rd=1: Rd=0 same cycle, all outputs 0
//    until release; WAIT_EN=0 build: mem_ready tied 0 still runs 2 cyc/instr.

Source files
------------

// File: rtl/mu0_control_if.sv
// ---------------------------------------------------------------------------
// mu0_control_if
// Signal bundle between the MU0 control FSM and its datapath.
//   master modport : control unit (consumes opcode/flags/ready, drives controls)
//   slave  modport : datapath     (drives opcode/flags/ready, consumes controls)
// Signals:
//   F[3:0]     opcode, IR[15:12]
//   N, Z       ACC negative / zero flags
//   mem_ready  memory completes the current Rd/Wr this cycle
//   X_sel      X mux: 0=ACC, 1=PC
//   Y_sel      Y mux: 0=memory data, 1=IR[11:0] zero-extended
//   Addr_sel   address mux: 0=PC, 1=IR[11:0]
//   PC_En, IR_En, Acc_En   register load enables
//   ALU_fs[1:0]  00=Y, 01=X+Y, 10=X+1, 11=X-Y
//   Rd, Wr     memory strobes
//   Halted     high in HALT state
// ---------------------------------------------------------------------------
interface mu0_control_if;
  logic [3:0] F;
  logic       N;
  logic       Z;
  logic       mem_ready;
  logic       X_sel;
  logic       Y_sel;
  logic       Addr_sel;
  logic       PC_En;
  logic       IR_En;
  logic       Acc_En;
  logic [1:0] ALU_fs;
  logic       Rd;
  logic       Wr;
  logic       Halted;

  modport master (
    input  F, N, Z, mem_ready,
    output X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, ALU_fs, Rd, Wr, Halted
  );

  modport slave (
    output F, N, Z, mem_ready,
    input  X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, ALU_fs, Rd, Wr, Halted
  );
endinterface

// File: rtl/mu0_control.sv
// ---------------------------------------------------------------------------
// mu0_control
// Control FSM for the MU0 16-bit processor. Sequences FETCH / EXECUTE / HALT
// and decodes the datapath mux selects, register enables, ALU function and
// memory strobes from state, opcode, ACC flags and the memory handshake.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; forces FETCH and zeroes every output
//   bus    mu0_control_if.master (opcode/flags/ready in, controls out)
// Parameter:
//   WAIT_EN  1: honour mem_ready; 0: memory is assumed to complete every cycle
// ---------------------------------------------------------------------------
module mu0_control #(
  parameter bit WAIT_EN = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mu0_control_if.master bus
);

  typedef enum logic [1:0] {
    S_FETCH   = 2'b00,
    S_EXECUTE = 2'b01,
    S_HALT    = 2'b10
  } state_t;

  localparam logic [1:0] ALU_Y   = 2'b00;
  localparam logic [1:0] ALU_ADD = 2'b01;
  localparam logic [1:0] ALU_INC = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  state_t r_state;
  state_t w_next;
  logic   w_ready;

  // With the handshake disabled every memory access completes in one cycle.
  assign w_ready = WAIT_EN ? bus.mem_ready : 1'b1;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    // NOTE: every output and the next state get a default before the case so
    // no path leaves a signal unassigned and no latch is inferred.
    bus.X_sel    = 1'b0;
    bus.Y_sel    = 1'b0;
    bus.Addr_sel = 1'b0;
    bus.PC_En    = 1'b0;
    bus.IR_En    = 1'b0;
    bus.Acc_En   = 1'b0;
    bus.ALU_fs   = ALU_Y;
    bus.Rd       = 1'b0;
    bus.Wr       = 1'b0;
    bus.Halted   = 1'b0;
    w_next       = r_state;

    case (r_state)
      S_FETCH: begin
        // Read the instruction at PC while the ALU forms PC+1.
        bus.Rd     = 1'b1;
        bus.X_sel  = 1'b1;
        bus.ALU_fs = ALU_INC;
        bus.IR_En  = w_ready;
        bus.PC_En  = w_ready;
        if (w_ready) w_next = S_EXECUTE;
      end

      S_EXECUTE: begin
        case (bus.F)
          4'h0: begin // LDA
            bus.Addr_sel = 1'b1;
            bus.Rd       = 1'b1;
            bus.ALU_fs   = ALU_Y;
            bus.Acc_En   = w_ready;
            if (w_ready) w_next = S_FETCH;
          end
          4'h1: begin // STA: ACC is routed through X to the write data
            bus.Addr_sel = 1'b1;
            bus.Wr       = 1'b1;
            if (w_ready) w_next = S_FETCH;
          end
          4'h2, 4'h3: begin // ADD / SUB
            bus.Addr_sel = 1'b1;
            bus.Rd       = 1'b1;
            bus.ALU_fs   = (bus.F == 4'h2) ? ALU_ADD : ALU_SUB;
            bus.Acc_En   = w_ready;
            if (w_ready) w_next = S_FETCH;
          end
          4'h4, 4'h5, 4'h6: begin // JMP / JGE / JNE: target is IR[11:0]
            bus.Y_sel  = 1'b1;
            bus.ALU_fs = ALU_Y;
            case (bus.F)
              4'h4:    bus.PC_En = 1'b1;
              4'h5:    bus.PC_En = ~bus.N;
              default: bus.PC_En = ~bus.Z;
            endcase
            w_next = S_FETCH;
          end
          default: w_next = S_HALT; // STP and all unused opcodes
        endcase
      end

      S_HALT: bus.Halted = 1'b1;

      default: w_next = S_FETCH;
    endcase

    // Reset silences the datapath combinationally, even mid-cycle.
    if (reset) begin
      bus.X_sel    = 1'b0;
      bus.Y_sel    = 1'b0;
      bus.Addr_sel = 1'b0;
      bus.PC_En    = 1'b0;
      bus.IR_En    = 1'b0;
      bus.Acc_En   = 1'b0;
      bus.ALU_fs   = ALU_Y;
      bus.Rd       = 1'b0;
      bus.Wr       = 1'b0;
      bus.Halted   = 1'b0;
      w_next       = S_FETCH;
    end
  end

endmodule

// File: tb/tb_mu0_control.sv
// ---------------------------------------------------------------------------
// tb_mu0_control
// Directed bench for mu0_control. A behavioural instruction-level model
// predicts the control word on every cycle; directed vectors additionally
// pin specific cycles to hand-written control words. A second instance with
// the handshake disabled checks two-cycle instructions with mem_ready tied 0.
// ---------------------------------------------------------------------------
module tb_mu0_control;

  logic clk;
  logic reset;
  logic reset2;

  mu0_control_if bus ();
  mu0_control_if bus2 ();

  mu0_control #(.WAIT_EN(1'b1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mu0_control #(.WAIT_EN(1'b0)) u_dut_nowait (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word order: X,Y,Addr,PC_En,IR_En,Acc_En,ALU_fs[1:0],Rd,Wr,Halted
  function automatic logic [10:0] pk(input logic x, y, a, pc, ir, acc,
                                     input logic [1:0] alu,
                                     input logic rd, wr, h);
    return {x, y, a, pc, ir, acc, alu, rd, wr, h};
  endfunction

  logic [10:0] w_dut1;
  logic [10:0] w_dut2;
  assign w_dut1 = {bus.X_sel, bus.Y_sel, bus.Addr_sel, bus.PC_En, bus.IR_En,
                   bus.Acc_En, bus.ALU_fs, bus.Rd, bus.Wr, bus.Halted};
  assign w_dut2 = {bus2.X_sel, bus2.Y_sel, bus2.Addr_sel, bus2.PC_En, bus2.IR_En,
                   bus2.Acc_En, bus2.ALU_fs, bus2.Rd, bus2.Wr, bus2.Halted};

  // Hand-written control words.
  logic [10:0] FETCH_R, FETCH_W, ADD_W, ADD_R, SUB_R, LDA_R, STA, JMP_T, JMP_N,
               NONE, HALTED;
  initial begin
    FETCH_R = pk(1, 0, 0, 1, 1, 0, 2'b10, 1, 0, 0);
    FETCH_W = pk(1, 0, 0, 0, 0, 0, 2'b10, 1, 0, 0);
    ADD_W   = pk(0, 0, 1, 0, 0, 0, 2'b01, 1, 0, 0);
    ADD_R   = pk(0, 0, 1, 0, 0, 1, 2'b01, 1, 0, 0);
    SUB_R   = pk(0, 0, 1, 0, 0, 1, 2'b11, 1, 0, 0);
    LDA_R   = pk(0, 0, 1, 0, 0, 1, 2'b00, 1, 0, 0);
    STA     = pk(0, 0, 1, 0, 0, 0, 2'b00, 0, 1, 0);
    JMP_T   = pk(0, 1, 0, 1, 0, 0, 2'b00, 0, 0, 0);
    JMP_N   = pk(0, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0);
    NONE    = 11'd0;
    HALTED  = pk(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 1);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int P_FETCH = 0;
  localparam int P_EXEC  = 1;
  localparam int P_HALT  = 2;

  int m_phase = P_FETCH;

  function automatic bit is_mem_op(input logic [3:0] f);
    return f <= 4'd3;
  endfunction

  function automatic bit is_jump(input logic [3:0] f);
    return f >= 4'd4 && f <= 4'd6;
  endfunction

  // What the datapath must be told to do, phrased per instruction meaning.
  function automatic logic [10:0] model_out(input int ph, input logic [3:0] f,
                                            input logic n, z, rdy, rst);
    logic x, y, a, pc, ir, acc, rd, wr, h;
    logic [1:0] alu;
    {x, y, a, pc, ir, acc, rd, wr, h} = '0;
    alu = 2'b00;
    if (rst) return 11'd0;
    if (ph == P_HALT) begin
      h = 1'b1;
    end else if (ph == P_FETCH) begin
      // Instruction read from PC, PC+1 computed, both registered on completion.
      rd = 1; x = 1; alu = 2'b10; ir = rdy; pc = rdy;
    end else if (is_mem_op(f)) begin
      a  = 1;
      wr = (f == 4'd1);
      rd = !wr;
      if (f == 4'd2) alu = 2'b01;
      if (f == 4'd3) alu = 2'b11;
      acc = rd & rdy;
    end else if (is_jump(f)) begin
      y  = 1;
      pc = (f == 4'd4) || (f == 4'd5 && !n) || (f == 4'd6 && !z);
    end
    return pk(x, y, a, pc, ir, acc, alu, rd, wr, h);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) m_phase <= P_FETCH;
    else begin
      case (m_phase)
        P_FETCH: if (bus.mem_ready) m_phase <= P_EXEC;
        P_EXEC: begin
          if (bus.F >= 4'd7)                              m_phase <= P_HALT;
          else if (!(is_mem_op(bus.F) && !bus.mem_ready)) m_phase <= P_FETCH;
        end
        default: m_phase <= P_HALT;
      endcase
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    check("model", w_dut1,
          model_out(m_phase, bus.F, bus.N, bus.Z, bus.mem_ready, reset));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc(input logic [3:0] f, input logic n, z, rdy,
                     input logic [10:0] exp, input string name);
    bus.F = f; bus.N = n; bus.Z = z; bus.mem_ready = rdy;
    @(negedge clk); #1;
    check(name, w_dut1, exp);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    @(negedge clk); #1;
    check(name, w_dut1, NONE);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    reset2 = 1'b1;
    bus.F = 4'h2; bus.N = 1'b0; bus.Z = 1'b0; bus.mem_ready = 1'b1;
    bus2.F = 4'h2; bus2.N = 1'b0; bus2.Z = 1'b0; bus2.mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset("reset_outputs_zero");

    // Basic fetch/execute
    cyc(4'h2, 0, 0, 1, FETCH_R, "t1_fetch");
    cyc(4'h2, 0, 0, 1, ADD_R,   "t1_add");

    // ADD with three wait cycles
    cyc(4'h2, 0, 0, 1, FETCH_R, "t2_fetch");
    cyc(4'h2, 0, 0, 0, ADD_W,   "t2_wait1");
    cyc(4'h2, 0, 0, 0, ADD_W,   "t2_wait2");
    cyc(4'h2, 0, 0, 0, ADD_W,   "t2_wait3");
    cyc(4'h2, 0, 0, 1, ADD_R,   "t2_done");

    cyc(4'h0, 0, 0, 1, FETCH_R, "lda_fetch");
    cyc(4'h0, 0, 0, 1, LDA_R,   "lda");
    cyc(4'h3, 0, 0, 1, FETCH_R, "sub_fetch");
    cyc(4'h3, 0, 0, 1, SUB_R,   "sub");

    // Fetch wait, then JMP ignores mem_ready
    cyc(4'h4, 0, 0, 0, FETCH_W, "fetch_wait");
    cyc(4'h4, 0, 0, 1, FETCH_R, "fetch_done");
    cyc(4'h4, 0, 0, 0, JMP_T,   "jmp");

    // Conditional jumps
    cyc(4'h5, 1, 0, 1, FETCH_R, "jge_fetch1");
    cyc(4'h5, 1, 0, 1, JMP_N,   "jge_negative");
    cyc(4'h5, 0, 0, 1, FETCH_R, "jge_fetch2");
    cyc(4'h5, 0, 0, 1, JMP_T,   "jge_positive");
    cyc(4'h6, 0, 1, 1, FETCH_R, "jne_fetch1");
    cyc(4'h6, 0, 1, 1, JMP_N,   "jne_zero");
    cyc(4'h6, 0, 0, 1, FETCH_R, "jne_fetch2");
    cyc(4'h6, 0, 0, 1, JMP_T,   "jne_nonzero");

    // STA with one wait
    cyc(4'h1, 0, 0, 1, FETCH_R, "sta_fetch");
    cyc(4'h1, 0, 0, 0, STA,     "sta_wait");
    cyc(4'h1, 0, 0, 1, STA,     "sta_done");
    cyc(4'h1, 0, 0, 1, FETCH_R, "sta_next_fetch");

    // STP then HALT held regardless of inputs
    cyc(4'h7, 0, 0, 1, NONE, "stp_exec");
    for (int i = 0; i < 10; i++)
      cyc(4'(i), 0, 0, i[0], HALTED, "halt_stp");
    do_reset("halt_stp_reset");

    // Unused opcode behaves like STP
    cyc(4'hC, 0, 0, 1, FETCH_R, "opc_fetch");
    cyc(4'hC, 0, 0, 1, NONE,    "opc_exec");
    for (int i = 0; i < 10; i++)
      cyc(4'(15 - i), i[0], i[1], i[0], HALTED, "halt_opc");
    do_reset("halt_opc_reset");

    // Reset in the middle of a fetch wait
    bus.F = 4'h2; bus.mem_ready = 1'b0;
    @(negedge clk); #1;
    check("t6_fetch_wait", w_dut1, FETCH_W);
    #2 reset = 1'b1;
    #1 check("t6_reset_same_cycle", w_dut1, NONE);
    @(posedge clk); #1;
    check("t6_reset_held", w_dut1, NONE);
    reset = 1'b0;
    cyc(4'h2, 0, 0, 1, FETCH_R, "t6_resume_fetch");
    cyc(4'h2, 0, 0, 1, ADD_R,   "t6_resume_add");

    // Handshake disabled: mem_ready tied 0 still gives 2 cycles/instruction
    @(negedge clk); #1;
    check("w0_in_reset", w_dut2, NONE);
    @(posedge clk); #1;
    reset2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus2.F = (i == 1) ? 4'h0 : 4'h2;
      @(negedge clk); #1;
      check("w0_fetch", w_dut2, FETCH_R);
      @(posedge clk); #1;
      @(negedge clk); #1;
      check("w0_exec", w_dut2, (i == 1) ? LDA_R : ADD_R);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
